// File: rtl/alu_seq_if.sv
// alu_seq_if: command/result handshake bundle between decode and the sequential ALU.
interface alu_seq_if #(
  parameter int W = 8,
  parameter int SHW = $clog2(W)
);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [3:0] op;
  logic [W-1:0] ina;
  logic [W-1:0] inb;
  logic [SHW-1:0] shamt;
  logic cin;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] result;
  logic cout;
  logic zero;
  logic illegal;
  logic busy;
  modport master (
    output flush, in_valid, op, ina, inb, shamt, cin, out_ready,
    input in_ready, out_valid, result, cout, zero, illegal, busy
  );
  modport slave (
    input flush, in_valid, op, ina, inb, shamt, cin, out_ready,
    output in_ready, out_valid, result, cout, zero, illegal, busy
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered results and bit-serial variable shifts.
module alu_seq #(
  parameter int W = 8,
  parameter int SHW = $clog2(W)
) (
  input logic Clk,
  input logic Reset_n,
  alu_seq_if.slave bus
);
  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] XOR = 4'b0010;
  localparam logic [3:0] AND = 4'b0011;
  localparam logic [3:0] LSH = 4'b0100;
  localparam logic [3:0] RSH = 4'b1101;
  localparam logic [3:0] CLR = 4'b0110;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [W-1:0] shiftReg, shiftNext, aluRes;
  logic [SHW-1:0] cnt;
  logic [W:0] sum;
  logic shiftLeft, shiftOut, aluCarry, aluIllegal, isShift, isShiftOp;
  assign sum = {1'b0, bus.ina} + {1'b0, bus.inb} + {{W{1'b0}}, bus.cin};
  always_comb begin
    isShiftOp = bus.op == LSH || bus.op == RSH;
    isShift = isShiftOp && bus.shamt != '0;
    aluRes = bus.op == ADD ? sum[W-1:0] :
             bus.op == XOR ? bus.ina ^ bus.inb :
             bus.op == AND ? bus.ina & bus.inb :
             isShiftOp ? bus.ina : '0;
    aluCarry = bus.op == ADD && sum[W];
    aluIllegal = !(bus.op inside {ADD, XOR, AND, LSH, RSH, CLR});
    shiftNext = shiftLeft ? shiftReg << 1 : shiftReg >> 1;
    shiftOut = shiftLeft ? shiftReg[W-1] : shiftReg[0];
  end
  assign bus.in_ready = state == IDLE || (state == DONE && bus.out_ready);
  assign bus.out_valid = state == DONE;
  assign bus.busy = state == SHIFT;
  // The shift runs in shiftReg so the visible result only moves on completion.
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= IDLE;
      cnt <= '0;
      shiftReg <= '0;
      shiftLeft <= 1'b0;
      bus.result <= '0;
      bus.cout <= 1'b0;
      bus.zero <= 1'b0;
      bus.illegal <= 1'b0;
    end else if (bus.flush) begin
      state <= IDLE;
      cnt <= '0;
    end else if (state == SHIFT) begin
      shiftReg <= shiftNext;
      cnt <= cnt - SHW'(1);
      if (cnt == SHW'(1)) begin
        state <= DONE;
        bus.result <= shiftNext;
        bus.cout <= shiftOut;
        bus.zero <= shiftNext == '0;
        bus.illegal <= 1'b0;
      end
    end else if (bus.in_valid && bus.in_ready) begin
      if (isShift) begin
        shiftReg <= bus.ina;
        cnt <= bus.shamt;
        shiftLeft <= bus.op == LSH;
        state <= SHIFT;
      end else begin
        bus.result <= aluRes;
        bus.cout <= aluCarry;
        bus.zero <= aluRes == '0;
        bus.illegal <= aluIllegal;
        state <= DONE;
      end
    end else if (bus.out_ready)
      state <= IDLE;
endmodule
